reg_readout: RTL and testbench
==============================

# reg_readout

Read-side companion to the 4-entry 8-bit register bank. Accepts read requests over a valid/ready handshake and returns register contents on a registered, back-pressurable response stream. Supports single-entry reads and 4-beat wrapping bursts. Sits between the register bank outputs (reg0..reg3) and any consumer that dumps or inspects bank state.

## Interface
Parameters:
- DATA_W, 8, width of each register and of resp_data
- NUM_REGS, 4, number of bank entries; fixed at 4, so addresses are 2 bits

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- reg0, reg1, reg2, reg3  input  DATA_W  live register bank outputs
- req_valid  input  1  read request present
- req_ready  output  1  block can accept a request
- req_addr  input  2  start entry
- req_burst  input  1  0 = single read, 1 = 4-beat wrapping burst
- resp_valid  output  1  response beat present
- resp_ready  input  1  consumer accepts beat
- resp_data  output  DATA_W  register contents
- resp_addr  output  2  entry index of this beat
- resp_last  output  1  final beat of the request
- resp_parity  output  1  even parity of resp_data; present only with READOUT_PARITY_EN

## Operation
- FSM states: IDLE and SEND.
- IDLE:
  - req_ready=1, resp_valid=0.
  - When req_valid && req_ready at an edge:
    - Load resp_data from the addressed reg sampled at that edge.
    - Set resp_addr=req_addr.
    - Set beats_left = 0 for single, 3 for burst.
    - Set resp_last = (beats_left==0).
    - Go to SEND.
- SEND:
  - req_ready=0, resp_valid=1.
  - resp_data, resp_addr and resp_last hold stable while resp_ready=0.
  - On resp_ready with resp_last=0:
    - resp_addr increments mod 4, so 3 wraps to 0.
    - resp_data is loaded from the new entry, sampled at that edge.
    - beats_left decrements.
    - resp_last becomes 1 when the new beats_left is 0.
  - On resp_ready with resp_last=1: go to IDLE; resp_valid=0 and resp_last=0 next cycle.
- Data is sampled at load time, not at request time. Bank writes that land before a beat loads are visible in that beat.
- Requests arriving while in SEND are not accepted. req_ready=0, and the requester holds its request.
- Bursts always cover all 4 entries, starting at req_addr. Example: a burst at addr 2 returns order 2,3,0,1.

## Timing
- Reset values: state IDLE, resp_valid=0, resp_data=0, resp_addr=0, resp_last=0, beats_left=0, req_ready=1. resp_parity=0 when compiled in.
- rst asserted mid-burst aborts the burst. All outputs take their reset values at the next edge, and no further beats are issued.
- Latency: a request accepted at edge N produces resp_valid=1 in the cycle after edge N.
- Throughput: with resp_ready held at 1, one beat per cycle. A burst spans 4 consecutive cycles.
- Last-beat acceptance at edge M gives req_ready=1 from edge M. The next request can be accepted at edge M+1, so there is a 1-cycle bubble between requests.
- req_ready is a pure function of state, with no combinational path from resp_ready.
- All resp_* outputs are registered.

## Configuration
- READOUT_PARITY_EN defined:
  - resp_parity port exists.
  - It is registered alongside resp_data and equals the XOR-reduce of the loaded data.
  - It holds stable under back-pressure.
- READOUT_PARITY_EN undefined: no resp_parity port or logic; all other behaviour is identical.

## Structure
- Shared package readout_pkg holds:
  - state typedef (IDLE, SEND)
  - DATA_W and ADDR_W=2 constants
  - NUM_REGS=4 constant
  - BURST_BEATS=4 constant
- One sub-module: readout_sel4, a combinational 4:1 select of reg0..reg3 by a 2-bit index. It feeds the resp_data load.
- beats_left and the FSM live in the top module.

## Test plan
- Single read: reg2=0xA5, request addr 2, single, resp_ready=1 -> one beat with data 0xA5, addr 2, last=1; req_ready back to 1 one cycle after acceptance.
- Burst wrap: regs = 0x10, 0x11, 0x12, 0x13; burst at addr 3 -> beats 0x13, 0x10, 0x11, 0x12 on consecutive cycles with addrs 3, 0, 1, 2; last only on the 4th beat.
- Back-pressure: burst at addr 0 with resp_ready low for 3 cycles on beat 2 -> beat 2 (addr 1, data reg1) held stable for all 3 cycles; no beat lost or duplicated.
- Live sampling: burst at 0, reg3 changed from 0x00 to 0x7E before beat 4 loads -> beat 4 returns 0x7E.
- Reset mid-burst: rst high during beat 2 -> next cycle resp_valid=0, resp_data=0, req_ready=1; a new single read at addr 1 then completes normally.
- Parity (READOUT_PARITY_EN): reg0=0x07 -> resp_parity=1; reg1=0x03 -> resp_parity=0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the register-bank readout path.
package readout_pkg;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 2;
  localparam int NUM_REGS    = 4;
  localparam int BURST_BEATS = 4;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/readout_sel4.sv
// Combinational 4:1 select of the live register bank outputs by a 2-bit index.
module readout_sel4 #(
  parameter int DATA_W = readout_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] reg0,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] reg3,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    data = reg0;
    case (sel)
      2'd1:    data = reg1;
      2'd2:    data = reg2;
      2'd3:    data = reg3;
      default: data = reg0;
    endcase
  end
endmodule

// File: rtl/reg_readout.sv
// Read-side companion to the 4-entry register bank: single reads and 4-beat wrapping bursts.
// Optional even-parity output is compiled in with READOUT_PARITY_EN.
module reg_readout #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           reg0,
  input  logic [DATA_W-1:0]           reg1,
  input  logic [DATA_W-1:0]           reg2,
  input  logic [DATA_W-1:0]           reg3,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_REGS)-1:0] req_addr,
  input  logic                        req_burst,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic [$clog2(NUM_REGS)-1:0] resp_addr,
  output logic                        resp_last
`ifdef READOUT_PARITY_EN
  ,
  output logic                        resp_parity
`endif
);
  import readout_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t            state_reg;
  logic [IDX_W-1:0]  beats_left_reg;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  next_addr;
  logic [DATA_W-1:0] sel_data;

  assign req_ready = (state_reg == IDLE);
  assign next_addr = resp_addr + IDX_W'(1);
  // One mux serves both the first load (request address) and every later beat.
  assign sel_idx   = (state_reg == IDLE) ? req_addr : next_addr;

  readout_sel4 #(.DATA_W(DATA_W)) u_sel (
    .reg0 (reg0),
    .reg1 (reg1),
    .reg2 (reg2),
    .reg3 (reg3),
    .sel  (sel_idx),
    .data (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_addr      <= '0;
      resp_last      <= 1'b0;
      beats_left_reg <= '0;
`ifdef READOUT_PARITY_EN
      resp_parity    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            resp_data      <= sel_data;
            resp_addr      <= req_addr;
            beats_left_reg <= req_burst ? IDX_W'(BURST_BEATS - 1) : '0;
            resp_last      <= ~req_burst;
            resp_valid     <= 1'b1;
            state_reg      <= SEND;
`ifdef READOUT_PARITY_EN
            resp_parity    <= ^sel_data;
`endif
          end
        end
        SEND: begin
          if (resp_ready) begin
            if (resp_last) begin
              resp_valid <= 1'b0;
              resp_last  <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              resp_addr      <= next_addr;
              resp_data      <= sel_data;
              beats_left_reg <= beats_left_reg - IDX_W'(1);
              resp_last      <= (beats_left_reg == IDX_W'(1));
`ifdef READOUT_PARITY_EN
              resp_parity    <= ^sel_data;
`endif
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_readout.sv
// Directed self-checking bench for reg_readout (parity checks with READOUT_PARITY_EN).
module tb_reg_readout;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg0, reg1, reg2, reg3;
  logic       req_valid, req_ready, req_burst;
  logic [1:0] req_addr;
  logic       resp_valid, resp_ready, resp_last;
  logic [7:0] resp_data;
  logic [1:0] resp_addr;
`ifdef READOUT_PARITY_EN
  logic       resp_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_readout #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg0       (reg0),
    .reg1       (reg1),
    .reg2       (reg2),
    .reg3       (reg3),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_burst  (req_burst),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_last  (resp_last)
`ifdef READOUT_PARITY_EN
    ,
    .resp_parity(resp_parity)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic [1:0] a, input logic l);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".data"},  32'(resp_data),  32'(d));
    check({tag, ".addr"},  32'(resp_addr),  32'(a));
    check({tag, ".last"},  32'(resp_last),  32'(l));
    check({tag, ".rdy"},   32'(req_ready),  32'd0);
    $display("beat %s data=0x%02h addr=%0d last=%0d", tag, resp_data, resp_addr, resp_last);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".last"},  32'(resp_last),  32'd0);
    check({tag, ".rdy"},   32'(req_ready),  32'd1);
    $display("idle %s", tag);
  endtask

  task automatic request(input logic [1:0] a, input logic b);
    req_valid = 1'b1;
    req_addr  = a;
    req_burst = b;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reg0 = 8'h00; reg1 = 8'h00; reg2 = 8'h00; reg3 = 8'h00;
    req_valid = 1'b0; req_addr = 2'd0; req_burst = 1'b0; resp_ready = 1'b1;
    step(); step();
    check_idle("reset");
    check("reset.data", 32'(resp_data), 32'h0);
    check("reset.addr", 32'(resp_addr), 32'h0);
    rst = 1'b0;

    // single read
    reg2 = 8'hA5;
    request(2'd2, 1'b0);
    check_beat("single", 8'hA5, 2'd2, 1'b1);
    step();
    check_idle("single_done");

    // wrapping burst from 3
    reg0 = 8'h10; reg1 = 8'h11; reg2 = 8'h12; reg3 = 8'h13;
    request(2'd3, 1'b1);
    check_beat("wrap0", 8'h13, 2'd3, 1'b0); step();
    check_beat("wrap1", 8'h10, 2'd0, 1'b0); step();
    check_beat("wrap2", 8'h11, 2'd1, 1'b0); step();
    check_beat("wrap3", 8'h12, 2'd2, 1'b1); step();
    check_idle("wrap_done");

    // back-pressure on beat 2; bank change during the stall must not leak
    reg0 = 8'h20; reg1 = 8'h21; reg2 = 8'h22; reg3 = 8'h23;
    request(2'd0, 1'b1);
    check_beat("bp0", 8'h20, 2'd0, 1'b0); step();
    check_beat("bp1", 8'h21, 2'd1, 1'b0);
    resp_ready = 1'b0; req_valid = 1'b1; reg1 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_beat($sformatf("bp_hold%0d", i), 8'h21, 2'd1, 1'b0);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    step();
    check_beat("bp2", 8'h22, 2'd2, 1'b0); step();
    check_beat("bp3", 8'h23, 2'd3, 1'b1); step();
    check_idle("bp_done");

    // live sampling: reg3 updated before beat 4 loads
    reg0 = 8'h30; reg1 = 8'h31; reg2 = 8'h32; reg3 = 8'h00;
    request(2'd0, 1'b1);
    check_beat("live0", 8'h30, 2'd0, 1'b0); step();
    check_beat("live1", 8'h31, 2'd1, 1'b0);
    reg3 = 8'h7E;
    step();
    check_beat("live2", 8'h32, 2'd2, 1'b0); step();
    check_beat("live3", 8'h7E, 2'd3, 1'b1); step();
    check_idle("live_done");

    // reset mid-burst, then a normal single read
    reg0 = 8'h40; reg1 = 8'h41; reg2 = 8'h42; reg3 = 8'h43;
    request(2'd0, 1'b1);
    check_beat("rst0", 8'h40, 2'd0, 1'b0); step();
    check_beat("rst1", 8'h41, 2'd1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_abort");
    check("rst_abort.data", 32'(resp_data), 32'h0);
    check("rst_abort.addr", 32'(resp_addr), 32'h0);
    step();
    check_idle("rst_quiet");
    reg1 = 8'h55;
    request(2'd1, 1'b0);
    check_beat("after_rst", 8'h55, 2'd1, 1'b1); step();
    check_idle("after_rst_done");

`ifdef READOUT_PARITY_EN
    reg0 = 8'h07; reg1 = 8'h03;
    request(2'd0, 1'b0);
    check("parity_07", 32'(resp_parity), 32'd1); step();
    request(2'd1, 1'b0);
    check("parity_03", 32'(resp_parity), 32'd0); step();
    check_idle("parity_done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
